ch2_tdm_demux4: RTL
===================

# ch2_tdm_demux4

Sequential 1-to-4 time-division demultiplexer, the receive-side counterpart of the 4:1 MUX block. It takes a serial stream produced by a 4:1 multiplexer with a rotating select and recovers the four lanes, aligned by a frame-sync marker. Samples are staged in shadow registers and presented to the four output lanes as one atomic frame. It sits downstream of the MUX-based serializer in the chapter-2 datapath.

## Interface
- `W`, default 1: width of each lane and of the serial input.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: asynchronous, active-high reset.
- `D` in W: serial sample, qualified by `EN`.
- `EN` in 1: the sample on `D` is valid this cycle.
- `FS` in 1: frame sync, qualified by `EN`; marks the current sample as slot 0.
- `Y` in 4*W, out: recovered lanes; `Y[W-1:0]` is slot 0 and `Y[4W-1:3W]` is slot 3.
- `SLOT` out 2: slot index the next valid sample will occupy.
- `DONE` out 1: one-cycle pulse; `Y` was updated by a complete frame.
- `LOCK` out 1: frame alignment is acquired.
- `ERR` out 1: one-cycle pulse; `FS` arrived at a slot other than 0 while locked.

## Operation
- The block has two states, `HUNT` and `RUN`. Reset enters `HUNT`.
- In `HUNT`:
  - `EN` without `FS` is ignored and `SLOT` stays 0.
  - `EN & FS` captures `D` into shadow slot 0, sets `SLOT=1` and moves to `RUN`.
- In `RUN`:
  - Each `EN` captures `D` into shadow slot `SLOT`, then `SLOT` increments modulo 4.
  - `EN` low holds everything; gaps of any length are legal.
- Frame completion: the edge that captures slot 3 also does all of the following.
  - Loads `Y` with the three shadow slots plus the current `D`.
  - Pulses `DONE`.
  - Wraps `SLOT` to 0.
- Once locked, `FS` is optional; the counter free-runs on `EN`.
- `EN & FS` with `SLOT==0` in `RUN` is normal and raises no error.
- `EN & FS` with `SLOT!=0` in `RUN` (misalignment):
  - The partial frame is discarded and `Y` is untouched.
  - `ERR` pulses.
  - The sample becomes slot 0 and `SLOT` is set to 1.
  - `LOCK` stays 1.
- `LOCK` is 1 exactly when the state is `RUN`.
- `Y` changes only on frame completion. It never shows a mix of two frames.

## Timing
- Reset values: `Y=0`, `SLOT=0`, `DONE=0`, `LOCK=0`, `ERR=0`, shadow registers 0, state `HUNT`.
- Reset asserted mid-frame clears everything immediately; no partial frame is ever emitted.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: `Y` and `DONE` update at the same edge that samples slot 3.
- `DONE` is high for exactly one cycle. The fastest frame rate (`EN` held high) gives one `DONE` every 4 cycles.
- `ERR` is high for exactly one cycle, following the offending edge.
- Misaligned `FS` on a slot-3 sample: the resync rule wins. There is no `DONE` and no `Y` update.
- `LOCK` rises at the edge after the first `EN & FS` sample.

## Structure
- Shared package `ch2_tdm_pkg`:
  - State enum `{HUNT, RUN}`.
  - `NUM_SLOTS=4` and `SLOT_W=2`.
- Sub-module `ch2_slot_cnt`: modulo-4 counter with enable, synchronous load-to-1 (for sync) and async reset. It outputs the count and a wrap flag.
- Top-level contents:
  - The FSM.
  - Shadow registers for slots 0–2; slot 3 is taken directly from `D`.
  - The `Y` register and the pulse generators.

## Test plan
- Reset, then `EN=1` with `FS=0` for 10 cycles → `LOCK=0`, `SLOT=0`, `DONE` never pulses, `Y=0`.
- `W=1`, `FS` on the first sample, `D`=1,0,1,1 on consecutive cycles → `DONE` pulses once at the 4th edge, `Y=4'b1101`, `LOCK=1`.
- Same frame with `EN` low for 3 cycles between each sample → identical `Y=4'b1101`, `DONE` delayed to the last sample, `SLOT` held during gaps.
- Locked stream with `FS` reasserted at `SLOT=2`:
  - `ERR` pulses once and no `DONE` occurs for the broken frame.
  - The next 4 samples 0,1,1,0 give `Y=4'b0110`.
- `RST` pulsed after 2 samples of a frame → all outputs 0 immediately, `HUNT` re-entered, and the next `FS`-aligned frame of 1,1,1,0 gives `Y=4'b0111`.
- Loopback from the 4:1 MUX driven by a free-running 2-bit select, `W=1`, 20 frames → `Y` equals the MUX lane inputs every frame, with `ERR` never asserted.

Source files
------------

// File: rtl/ch2_tdm_pkg.sv
// Shared types and constants for the chapter-2 TDM datapath.
//   NUM_SLOTS / SLOT_W : slots per frame and width of a slot index
//   state_e            : demultiplexer alignment state (HUNT, RUN)
//   slot_t             : slot index type
//   LAST_SLOT          : index of the slot that completes a frame
package ch2_tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

endpackage : ch2_tdm_pkg

// File: rtl/ch2_slot_cnt.sv
// Modulo-NUM_SLOTS slot counter with increment enable and a synchronous
// load-to-1 used when a frame-sync sample is taken as slot 0.
//   clk_i     : rising-edge clock
//   rst_i     : asynchronous active-high reset, clears the count
//   inc_i     : advance the count by one (wraps after LAST_SLOT)
//   load1_i   : force the count to 1; has priority over inc_i
//   cnt_o     : registered slot index
//   wrap_c_o  : combinational, high when this edge advances past LAST_SLOT
module ch2_slot_cnt
  import ch2_tdm_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  inc_i,
  input  logic  load1_i,
  output slot_t cnt_o,
  output logic  wrap_c_o
);

  slot_t cnt_q;
  slot_t cnt_d;

  // Next count: load wins over increment; natural overflow gives the wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load1_i) begin
      cnt_d = slot_t'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign wrap_c_o = inc_i & ~load1_i & (cnt_q == LAST_SLOT);

endmodule : ch2_slot_cnt

// File: rtl/ch2_tdm_demux4.sv
// 1-to-4 time-division demultiplexer. Recovers four lanes from a serial
// stream aligned by a frame-sync marker; samples are staged in shadow
// registers and Y is loaded atomically when the last slot arrives.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   D    : serial sample (W bits), qualified by EN
//   EN   : sample valid
//   FS   : frame sync, qualified by EN; marks the sample as slot 0
//   Y    : recovered lanes, Y[W-1:0] is slot 0
//   SLOT : slot the next valid sample will occupy
//   DONE : one-cycle pulse, Y was loaded with a complete frame
//   LOCK : frame alignment acquired
//   ERR  : one-cycle pulse, FS seen at a nonzero slot while locked
module ch2_tdm_demux4
  import ch2_tdm_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [W-1:0]           D,
  input  logic                   EN,
  input  logic                   FS,
  output logic [NUM_SLOTS*W-1:0] Y,
  output logic [SLOT_W-1:0]      SLOT,
  output logic                   DONE,
  output logic                   LOCK,
  output logic                   ERR
);

  state_e                          state_q;
  logic [NUM_SLOTS-2:0][W-1:0]     shadow_q;
  logic [NUM_SLOTS*W-1:0]          y_q;
  logic                            done_q;
  logic                            err_q;

  slot_t slot;
  logic  wrap_c;
  logic  run_c;
  logic  sync_c;
  logic  adv_c;
  logic  misalign_c;

  // Sample qualification: a sync sample always becomes slot 0; plain samples
  // only count once aligned.
  always_comb begin
    run_c      = (state_q == RUN);
    sync_c     = EN & FS;
    adv_c      = EN & ~FS & run_c;
    misalign_c = sync_c & run_c & (slot != '0);
  end

  ch2_slot_cnt u_slot_cnt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .inc_i    (adv_c),
    .load1_i  (sync_c),
    .cnt_o    (slot),
    .wrap_c_o (wrap_c)
  );

  // Alignment FSM, shadow capture, frame output and status pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= wrap_c;
      err_q  <= misalign_c;
      if (sync_c) begin
        // Resync discards any partial frame; Y is left alone.
        state_q     <= RUN;
        shadow_q[0] <= D;
      end else if (adv_c) begin
        if (wrap_c) begin
          // Last slot bypasses the shadows so Y updates on this same edge.
          y_q <= {D, shadow_q};
        end else begin
          for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
            if (slot == slot_t'(i)) begin
              shadow_q[i] <= D;
            end
          end
        end
      end
    end
  end

  assign Y    = y_q;
  assign SLOT = slot;
  assign DONE = done_q;
  assign LOCK = (state_q == RUN);
  assign ERR  = err_q;

endmodule : ch2_tdm_demux4
